// File: rtl/ring_router_gateway_arbiter_if.sv
// DII flit link: valid/last/data travel downstream, ready travels back upstream.
interface ring_router_gateway_arbiter_if;
   logic        valid;
   logic        last;
   logic [15:0] data;
   logic        ready;

   modport master (output valid, last, data, input ready);
   modport slave  (input valid, last, data, output ready);
endinterface

// File: rtl/ring_router_gateway_arbiter.sv
// Worm-level weighted round-robin merge of ring, local and external flit sources
// onto the outgoing ring link; combinational datapath, registered arbitration state.
module ring_router_gateway_arbiter #(
   parameter int RING_WEIGHT = 2,
   parameter int CNT_BITS    = 4
) (
   input  logic                                clk,
   input  logic                                rst,
   ring_router_gateway_arbiter_if.slave        in_ring,
   ring_router_gateway_arbiter_if.slave        in_local,
   ring_router_gateway_arbiter_if.slave        in_ext,
   ring_router_gateway_arbiter_if.master       out_ring,
   output logic [2:0]                          grant
);

   localparam logic [CNT_BITS-1:0] WEIGHT_C = CNT_BITS'(RING_WEIGHT);

   logic                locked_r;
   logic [1:0]          lock_sel_r;
   logic [1:0]          last_sel_r;
   logic [CNT_BITS-1:0] ring_cnt_r;

   logic [3:0]          vld_s;
   logic [1:0]          cand1_s;
   logic [1:0]          cand2_s;
   logic [1:0]          sel_s;
   logic                sel_vld_s;
   logic                xfer_last_s;

   function automatic logic [1:0] wrap_inc(input logic [1:0] s);
      logic [1:0] r;
      if (s >= 2'd2) begin
         r = 2'd0;
      end else begin
         r = s + 2'd1;
      end
      return r;
   endfunction

   // Index 3 never carries a source, so it reads as permanently idle.
   assign vld_s   = {1'b0, in_ext.valid, in_local.valid, in_ring.valid};
   assign cand1_s = wrap_inc(last_sel_r);
   assign cand2_s = wrap_inc(cand1_s);

   // Source selection: held worm first, then ring weight credit, then rotating scan
   always_comb begin
      sel_s     = 2'd0;
      sel_vld_s = 1'b0;
      if (rst) begin
         sel_vld_s = 1'b0;
      end else if (locked_r) begin
         sel_s     = lock_sel_r;
         sel_vld_s = 1'b1;
      end else if ((last_sel_r == 2'd0) && vld_s[0] && (ring_cnt_r < WEIGHT_C)) begin
         sel_s     = 2'd0;
         sel_vld_s = 1'b1;
      end else if (vld_s[cand1_s]) begin
         sel_s     = cand1_s;
         sel_vld_s = 1'b1;
      end else if (vld_s[cand2_s]) begin
         sel_s     = cand2_s;
         sel_vld_s = 1'b1;
      end else if (vld_s[last_sel_r]) begin
         sel_s     = last_sel_r;
         sel_vld_s = 1'b1;
      end else begin
         sel_vld_s = 1'b0;
      end
   end

   // Flit mux and ready steering toward the selected source only
   always_comb begin
      out_ring.valid = 1'b0;
      out_ring.last  = 1'b0;
      out_ring.data  = 16'h0000;
      in_ring.ready  = 1'b0;
      in_local.ready = 1'b0;
      in_ext.ready   = 1'b0;
      if (sel_vld_s) begin
         case (sel_s)
            2'd0: begin
               out_ring.valid = in_ring.valid;
               out_ring.last  = in_ring.last;
               out_ring.data  = in_ring.data;
               in_ring.ready  = out_ring.ready;
            end
            2'd1: begin
               out_ring.valid = in_local.valid;
               out_ring.last  = in_local.last;
               out_ring.data  = in_local.data;
               in_local.ready = out_ring.ready;
            end
            2'd2: begin
               out_ring.valid = in_ext.valid;
               out_ring.last  = in_ext.last;
               out_ring.data  = in_ext.data;
               in_ext.ready   = out_ring.ready;
            end
            default: begin
               out_ring.valid = 1'b0;
            end
         endcase
      end else begin
         out_ring.valid = 1'b0;
      end
   end

   // One-hot view of the current selection
   always_comb begin
      grant = 3'b000;
      if (sel_vld_s) begin
         grant = 3'b001 << sel_s;
      end else begin
         grant = 3'b000;
      end
   end

   assign xfer_last_s = out_ring.valid & out_ring.ready & out_ring.last;

   // Arbitration state: lock on offer, release and account on last-flit transfer
   always_ff @(posedge clk) begin
      if (rst) begin
         locked_r   <= 1'b0;
         lock_sel_r <= 2'd0;
         last_sel_r <= 2'd2;
         ring_cnt_r <= '0;
      end else if (xfer_last_s) begin
         locked_r   <= 1'b0;
         last_sel_r <= sel_s;
         if (sel_s == 2'd0) begin
            ring_cnt_r <= (ring_cnt_r >= WEIGHT_C) ? WEIGHT_C : ring_cnt_r + CNT_BITS'(1);
         end else begin
            ring_cnt_r <= '0;
         end
      end else if (!locked_r && sel_vld_s) begin
         locked_r   <= 1'b1;
         lock_sel_r <= sel_s;
      end else begin
         locked_r   <= locked_r;
      end
   end

endmodule

// File: tb/tb_ring_router_gateway_arbiter.sv
// Randomized bench for the gateway arbiter: drivers push presented flits into per-source
// queues, a negedge monitor predicts the owning source and checks every output.
module tb_ring_router_gateway_arbiter;
   localparam int W = 2;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic [2:0] grant;
   logic out_ready = 1'b0;

   logic        v [3];
   logic        l [3];
   logic [15:0] d [3];

   ring_router_gateway_arbiter_if if_ring ();
   ring_router_gateway_arbiter_if if_local ();
   ring_router_gateway_arbiter_if if_ext ();
   ring_router_gateway_arbiter_if if_out ();

   assign if_ring.valid  = v[0];
   assign if_ring.last   = l[0];
   assign if_ring.data   = d[0];
   assign if_local.valid = v[1];
   assign if_local.last  = l[1];
   assign if_local.data  = d[1];
   assign if_ext.valid   = v[2];
   assign if_ext.last    = l[2];
   assign if_ext.data    = d[2];
   assign if_out.ready   = out_ready;

   ring_router_gateway_arbiter #(.RING_WEIGHT(W), .CNT_BITS(4)) dut (
      .clk      (clk),
      .rst      (rst),
      .in_ring  (if_ring),
      .in_local (if_local),
      .in_ext   (if_ext),
      .out_ring (if_out),
      .grant    (grant)
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;
   int xfers = 0;
   bit phase_a = 1'b0;
   int gnt_log [$];
   logic [16:0] exp_q [3][$];

   // stimulus knobs and driver state
   int p_start [3];
   int gap_pct  = 0;
   int rdy_pct  = 100;
   bit single   = 1'b1;
   bit in_pkt [3];
   int rem    [3];
   int plen   [3];
   int seq    [3];

   // reference model state
   int owner  = -1;
   int m_last = 2;
   int m_cnt  = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Next packet owner from the arbitration rules, given the set of valid sources.
   function automatic int pick(input bit [2:0] vm);
      if (m_last == 0 && vm[0] && m_cnt < W) return 0;
      for (int k = 1; k <= 3; k++) begin
         int c;
         c = (m_last + k) % 3;
         if (vm[c]) return c;
      end
      return -1;
   endfunction

   always @(negedge clk) begin
      logic [2:0]  rdys;
      logic [16:0] e;
      bit   [2:0]  vm;
      rdys = {if_ext.ready, if_local.ready, if_ring.ready};
      if (rst) begin
         check("reset_outputs", {28'd0, if_out.valid, grant} | {29'd0, rdys}, 32'd0);
         owner  = -1;
         m_last = 2;
         m_cnt  = 0;
      end else begin
         vm = {v[2], v[1], v[0]};
         if (owner < 0 && vm != 3'b000) owner = pick(vm);
         check("grant", {29'd0, grant}, (owner < 0) ? 32'd0 : (32'd1 << owner));
         check("ready", {29'd0, rdys}, (owner < 0 || !out_ready) ? 32'd0 : (32'd1 << owner));
         check("out_valid", {31'd0, if_out.valid}, (owner >= 0 && v[owner]) ? 32'd1 : 32'd0);
         if (owner >= 0 && v[owner] && out_ready) begin
            xfers++;
            if (phase_a) gnt_log.push_back(int'(grant));
            if (exp_q[owner].size() == 0) begin
               check("queue_empty", 32'd1, 32'd0);
               owner = -1;
            end else begin
               e = exp_q[owner].pop_front();
               check("flit", {15'd0, if_out.last, if_out.data}, {15'd0, e});
               if (e[16]) begin
                  m_cnt  = (owner == 0) ? ((m_cnt + 1 > W) ? W : m_cnt + 1) : 0;
                  m_last = owner;
                  owner  = -1;
               end
            end
         end
      end
   end

   // One clock of source behaviour: retire accepted flits, maybe present new ones.
   task automatic step();
      bit acc [3];
      @(negedge clk);
      acc[0] = v[0] && if_ring.ready;
      acc[1] = v[1] && if_local.ready;
      acc[2] = v[2] && if_ext.ready;
      @(posedge clk);
      #1;
      for (int i = 0; i < 3; i++) begin
         if (acc[i]) begin
            rem[i]--;
            if (l[i]) in_pkt[i] = 1'b0;
            v[i] = 1'b0;
            l[i] = 1'b0;
         end
         if (!v[i]) begin
            if (!in_pkt[i] && ($urandom_range(99) < p_start[i])) begin
               plen[i]   = single ? 1 : $urandom_range(1, 4);
               rem[i]    = plen[i];
               in_pkt[i] = 1'b1;
            end
            if (in_pkt[i] && ($urandom_range(99) >= gap_pct)) begin
               d[i] = {i[1:0], seq[i][13:0]};
               seq[i]++;
               l[i] = (rem[i] == 1);
               v[i] = 1'b1;
               exp_q[i].push_back({l[i], d[i]});
            end
         end
      end
      out_ready = ($urandom_range(99) < rdy_pct);
   endtask

   task automatic do_reset(input int cycles);
      @(posedge clk);
      #1;
      rst = 1'b1;
      for (int i = 0; i < 3; i++) begin
         v[i] = 1'b0;
         l[i] = 1'b0;
         in_pkt[i] = 1'b0;
         exp_q[i].delete();
      end
      repeat (cycles) @(posedge clk);
      #1;
      rst = 1'b0;
   endtask

   initial begin
      int exp_order [8];
      int found;
      exp_order = '{1, 1, 2, 4, 1, 1, 2, 4};
      for (int i = 0; i < 3; i++) begin
         v[i] = 1'b0; l[i] = 1'b0; d[i] = 16'h0000;
         in_pkt[i] = 1'b0; rem[i] = 0; plen[i] = 0; seq[i] = 0;
         p_start[i] = 100;
      end
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0;

      // all sources saturated with single-flit packets, sink always ready
      phase_a = 1'b1;
      repeat (40) step();
      phase_a = 1'b0;

      // multi-flit worms with gaps and moderate backpressure
      single = 1'b0; gap_pct = 25; rdy_pct = 70;
      for (int i = 0; i < 3; i++) p_start[i] = 60;
      repeat (1200) step();

      // heavy backpressure: long stalls on offered flits
      rdy_pct = 20;
      repeat (400) step();

      // ring alone, then contenders return
      rdy_pct = 100; gap_pct = 0; single = 1'b1;
      p_start[1] = 0; p_start[2] = 0; p_start[0] = 100;
      repeat (30) step();
      p_start[1] = 100; p_start[2] = 100;
      repeat (30) step();

      // reset on flit 2 of a 3-flit local packet (bounded search)
      single = 1'b0; rdy_pct = 60; gap_pct = 10;
      for (int r = 0; r < 3; r++) begin
         found = 0;
         for (int c = 0; c < 400 && found == 0; c++) begin
            step();
            if (v[1] && plen[1] == 3 && rem[1] == 2) found = 1;
         end
         do_reset(2);
         repeat (200) step();
      end

      rdy_pct = 100; gap_pct = 0;
      repeat (20) step();

      check("xfer_count_min", (xfers >= 300) ? 32'd1 : 32'd0, 32'd1);
      check("order_log_size", (gnt_log.size() >= 8) ? 32'd1 : 32'd0, 32'd1);
      for (int k = 0; k < 8; k++) begin
         if (k < gnt_log.size()) check("wrr_order", gnt_log[k], exp_order[k]);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
